// File: rtl/stream_sink_chk.sv
// Stream sink/checker: programmable back-pressure, capture and expected-memory compare.
// Optional stall watchdog enabled by defining STREAM_SINK_TIMEOUT_EN.
`timescale 1ns/1ps
module stream_sink_chk #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 1024,
    parameter int          CNT_W     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          TIMEOUT   = 4096,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n,
    input  logic [1:0]        mode,
    input  logic [3:0]        duty,
    input  logic [DATA_W-1:0] val,
    input  logic              valid,
    output logic              ready,
    output logic              finish,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic              timeout,
    input  logic              exp_we,
    input  logic [AW-1:0]     exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t state_q, state_d;

    logic              s0, s1;
    logic              st_edge;
    logic [CNT_W-1:0]  n_q;
    logic [1:0]        mode_q;
    logic [3:0]        duty_q;
    logic [CNT_W-1:0]  idx;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nx;
    logic [3:0]        pcnt;
    logic              rdy_nx;
    logic              run;
    logic              xfer;
    logic              last;
    logic              mismatch;
    logic              wd_fire;
    logic [AW-1:0]     addr;

    logic [DATA_W-1:0] cap_mem [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];

    assign st_edge  = s0 & ~s1;
    assign run      = (state_q == RUN);
    assign xfer     = reset_n & run & valid & ready;
    assign addr     = idx[AW-1:0];
    assign last     = (idx + CNT_W'(1)) == n_q;
    // exp_mem is read before this edge's write lands: read-before-write
    assign mismatch = exp_mem[addr] != val;
    assign dbg_data = cap_mem[dbg_addr];

    // Galois LFSR, taps 16,14,13,11
    assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        rdy_nx = 1'b1;
        unique case (mode_q)
            2'b01:   rdy_nx = (lfsr[3:0] <= duty_q);
            2'b10:   rdy_nx = (pcnt == duty_q);
            default: rdy_nx = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (st_edge) begin
            state_d = (n == '0) ? FIN : RUN;
        end else if (run && ((xfer && last) || wd_fire)) begin
            state_d = FIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s0            <= 1'b0;
            s1            <= 1'b0;
            n_q           <= '0;
            mode_q        <= 2'b00;
            duty_q        <= 4'd0;
            idx           <= '0;
            err_cnt       <= '0;
            first_err_idx <= '1;
            finish        <= 1'b0;
            ready         <= 1'b0;
            lfsr          <= LFSR_SEED;
            pcnt          <= 4'd0;
        end else begin
            s0 <= start;
            s1 <= s0;
            if (st_edge) begin
                n_q           <= n;
                mode_q        <= mode;
                duty_q        <= duty;
                idx           <= '0;
                err_cnt       <= '0;
                first_err_idx <= '1;
                finish        <= 1'b0;
                ready         <= 1'b0;
                lfsr          <= LFSR_SEED;
                pcnt          <= 4'd0;
            end else begin
                unique case (state_q)
                    RUN: begin
                        lfsr  <= lfsr_nx;
                        pcnt  <= (pcnt == duty_q) ? 4'd0 : pcnt + 4'd1;
                        ready <= rdy_nx;
                        if (xfer) begin
                            idx <= idx + CNT_W'(1);
                            if (mismatch) begin
                                if (err_cnt != '1) begin
                                    err_cnt <= err_cnt + CNT_W'(1);
                                end
                                if (first_err_idx == '1) begin
                                    first_err_idx <= idx;
                                end
                            end
                            if (last) begin
                                ready <= 1'b0;
                            end
                        end
                        if (wd_fire) begin
                            ready <= 1'b0;
                        end
                    end
                    FIN: begin
                        ready  <= 1'b0;
                        finish <= 1'b1;
                    end
                    default: begin
                        ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Memories are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (exp_we) begin
            exp_mem[exp_addr] <= exp_data;
        end
        if (xfer) begin
            cap_mem[addr] <= val;
        end
    end

`ifdef STREAM_SINK_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wdog;
    logic          to_q;

    assign wd_fire = run & ~xfer & (wdog == WW'(TIMEOUT - 1));
    assign timeout = to_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog <= '0;
            to_q <= 1'b0;
        end else if (st_edge) begin
            wdog <= '0;
            to_q <= 1'b0;
        end else if (run) begin
            if (xfer) begin
                wdog <= '0;
            end else if (wd_fire) begin
                wdog <= '0;
                to_q <= 1'b1;
            end else begin
                wdog <= wdog + WW'(1);
            end
        end
    end
`else
    // Watchdog compiled out; the term only keeps TIMEOUT referenced
    assign wd_fire = 1'b0 && (TIMEOUT != 0);
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stream_sink_chk.sv
// Randomized bench for stream_sink_chk with a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_stream_sink_chk;
    localparam int DW = 32;
    localparam int D  = 32;
    localparam int CW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [CW-1:0] n;
    logic [1:0]    mode;
    logic [3:0]    duty;
    logic [DW-1:0] val;
    logic          valid;
    logic          ready;
    logic          finish;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] first_err_idx;
    logic          timeout;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    stream_sink_chk #(
        .DATA_W(DW), .DEPTH(D), .CNT_W(CW),
        .LFSR_SEED(16'hACE1), .TIMEOUT(4096)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .n(n),
        .mode(mode), .duty(duty), .val(val), .valid(valid),
        .ready(ready), .finish(finish), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .timeout(timeout),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int last_fin_k;
    logic [DW-1:0] exp_m [D];
    logic [DW-1:0] cap_m [D];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    function automatic logic [15:0] galois(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic preload(input bit rnd);
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            exp_we   = 1'b1;
            exp_addr = AW'(i);
            exp_data = rnd ? $urandom : DW'(i);
            exp_m[i] = exp_data;
        end
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    task automatic run_test(input int nn, input int md, input int dt,
                            input int vprob, input int ca, input int cb,
                            input int max_x, input bit rbw);
        int midx, k, age, budget, a, wa, lim;
        logic [31:0] merr, mfirst;
        logic [DW-1:0] word, wd;
        logic [15:0] lf;
        bit done, r, v, xf, we;
        @(negedge clk);
        n = CW'(nn); mode = 2'(md); duty = 4'(dt);
        valid = 1'b0; exp_we = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        midx = 0; merr = 0; mfirst = '1; done = (nn == 0); age = 0;
        r = 1'b0; lf = 16'hACE1; k = 0; budget = 400 * nn + 100;
        while (1) begin
            chk("ready", ready, r);
            chk("err_cnt", err_cnt, merr);
            chk("first_err_idx", first_err_idx, mfirst);
            chk("finish", finish, done && age >= 1);
            chk("timeout", timeout, 1'b0);
            if (done && age >= 1) begin
                last_fin_k = k;
                break;
            end
            if (done) age++;
            if (!done && midx == max_x) break;
            if (k > budget) begin
                chk("run_budget", k, budget);
                break;
            end
            v = ($urandom_range(99) < vprob);
            word = exp_m[midx % D];
            if (midx == ca || midx == cb) word = word ^ 32'h1;
            if (!(v && r)) word = $urandom;
            we = rbw && ($urandom_range(3) == 0);
            wa = $urandom_range(1) ? (midx % D) : $urandom_range(D - 1);
            wd = $urandom;
            valid = v; val = word;
            exp_we = we; exp_addr = AW'(wa); exp_data = wd;
            xf = v && r && !done;
            if (xf) begin
                a = midx % D;
                if (word != exp_m[a]) begin
                    merr++;
                    if (mfirst == '1) mfirst = midx;
                end
                cap_m[a] = word;
                midx++;
                if (midx == nn) done = 1'b1;
            end
            if (we) exp_m[wa] = wd;
            if (done) r = 1'b0;
            else if (md == 1) r = (lf[3:0] <= 4'(dt));
            else if (md == 2) r = ((k % (dt + 1)) == dt);
            else r = 1'b1;
            lf = galois(lf);
            k++;
            @(negedge clk);
        end
        valid = 1'b0; exp_we = 1'b0;
        if (done) begin
            lim = (nn < D) ? nn : D;
            for (int i = 0; i < lim; i++) begin
                dbg_addr = AW'(i);
                #1;
                chk("dbg_cap", dbg_data, cap_m[i]);
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: got expired want finished");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; n = '0; mode = 2'b00; duty = 4'd0;
        val = '0; valid = 1'b0; exp_we = 1'b0; exp_addr = '0;
        exp_data = '0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1'b0);
        chk("rst_finish", finish, 1'b0);
        chk("rst_err", err_cnt, 32'd0);
        chk("rst_first", first_err_idx, 32'hFFFF_FFFF);
        chk("rst_timeout", timeout, 1'b0);
        reset_n = 1'b1;

        preload(1'b0);
        run_test(20, 0, 0, 100, -1, -1, -1, 1'b0);
        chk("m00_fin_k", last_fin_k, 22);
        chk("m00_err", err_cnt, 32'd0);
        chk("m00_first", first_err_idx, 32'hFFFF_FFFF);
        dbg_addr = 5'd5;
        #1;
        chk("m00_dbg5", dbg_data, 32'd5);

        preload(1'b1);
        run_test(100, 1, 7, 70, -1, -1, -1, 1'b1);
        chk("m01_err", err_cnt, 32'd0);

        preload(1'b1);
        run_test(8, 2, 3, 100, -1, -1, -1, 1'b0);
        chk("m10_fin_k", last_fin_k, 34);

        preload(1'b1);
        run_test(10, 0, 0, 80, 3, 7, -1, 1'b0);
        chk("corr_err", err_cnt, 32'd2);
        chk("corr_first", first_err_idx, 32'd3);

        run_test(0, 0, 0, 100, -1, -1, -1, 1'b0);
        chk("n0_fin_k", last_fin_k, 1);
        repeat (3) begin
            @(negedge clk);
            chk("n0_ready", ready, 1'b0);
            chk("n0_finish", finish, 1'b1);
        end

        run_test(30, 1, 9, 90, 2, -1, 10, 1'b1);
        run_test(40, 1, 15, 60, -1, -1, -1, 1'b1);

        run_test(12, 0, 0, 100, 1, -1, 5, 1'b0);
        chk("pre_rst_err", err_cnt, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", ready, 1'b0);
        chk("mid_rst_finish", finish, 1'b0);
        chk("mid_rst_err", err_cnt, 32'd0);
        chk("mid_rst_first", first_err_idx, 32'hFFFF_FFFF);
        reset_n = 1'b1;
        run_test(4, 0, 0, 100, -1, -1, -1, 1'b0);
        chk("post_rst_err", err_cnt, 32'd0);

        repeat (6) begin
            run_test($urandom_range(60, 1), $urandom_range(3),
                     $urandom_range(15), $urandom_range(100, 50),
                     $urandom_range(70), -1, -1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
